wm8731_cfg_seq: RTL and testbench

- Parametrised successor to the codec configuration path.
- Merges the SCL clock divider, the register-table sequencer and the I2C write master into one single-clock engine.
- After reset or `start`, writes NUM_REGS 24-bit frames to the WM8731: {slave addr+W, reg[6:0] & data[8], data[7:0]}.
- Afterwards it services runtime volume and sound-select changes by rewriting only the affected register.
- Reports busy, done and NACK errors to the top level.

---
 rtl/wm8731_cfg_seq_if.sv | 20 ++
 rtl/wm8731_cfg_seq.sv | 273 +++++++++++++++++++++++++++
 tb/tb_wm8731_cfg_seq.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wm8731_cfg_seq_if.sv
// Control/status bundle between the WM8731 configuration engine and its user logic.
interface wm8731_cfg_seq_if;
    logic       start;
    logic       volume_up;
    logic       volume_down;
    logic [2:0] sound_select;
    logic       busy;
    logic       done;
    logic       nack_err;
    logic [6:0] volume;

    modport master (
        output start, volume_up, volume_down, sound_select,
        input  busy, done, nack_err, volume
    );
    modport slave (
        input  start, volume_up, volume_down, sound_select,
        output busy, done, nack_err, volume
    );
endinterface

// File: rtl/wm8731_cfg_seq.sv
// WM8731 configuration engine: SCL divider, register-table sequencer and I2C write master.
// Define CFG_RETRY_EN to re-send NACKed frames up to MAX_RETRY times before flagging nack_err.
module wm8731_cfg_seq #(
    parameter int unsigned CLK_DIV     = 125,
    parameter int unsigned NUM_REGS    = 10,
    parameter logic [6:0]  SLAVE_ADDR  = 7'h1A,
    parameter logic [6:0]  VOL_DEFAULT = 7'h79,
    parameter logic [6:0]  VOL_MIN     = 7'h30,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned GAP_TICKS   = 4
) (
    input  logic            clock,
    input  logic            reset,
    wm8731_cfg_seq_if.slave bus,
    inout  wire             I2C_SDAT,
    output logic            I2C_SCLK
);

`ifdef CFG_RETRY_EN
    localparam bit RetryEn = 1'b1;
`else
    localparam bit RetryEn = 1'b0;
`endif

    localparam logic [6:0] VolMax   = 7'h7F;
    localparam logic [9:0] TickLast = 10'(CLK_DIV - 1);
    localparam logic [3:0] LastIdx  = 4'(NUM_REGS - 1);
    localparam logic [7:0] GapLast  = 8'(GAP_TICKS - 1);
    localparam logic [3:0] MaxRetry = 4'(MAX_RETRY);

    typedef enum logic [3:0] {
        StIdle, StLoad, StStart, StBit, StAck, StStop, StGap, StErr, StFinish
    } state_e;

    state_e      state_q, state_d;
    logic [9:0]  tick_q, tick_d;
    logic [1:0]  phase_q, phase_d;
    logic [4:0]  bit_q, bit_d;
    logic [23:0] shreg_q, shreg_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  gap_q, gap_d;
    logic [3:0]  retry_q, retry_d;
    logic [6:0]  vol_q, vol_d;
    logic [2:0]  sel_q, sel_d;
    logic        single_q, single_d, again_q, again_d, nack_q, nack_d;
    logic        scl_q, scl_d, sda_low_q, sda_low_d, done_q, done_d, nack_err_q, nack_err_d;
    logic        full_pend_q, full_pend_d, vol_pend_q, vol_pend_d, sel_pend_q, sel_pend_d;
    logic        qtick;
    logic [15:0] entry;

    // {reg[6:0], data[8:0]} for a table slot; slots past 9 repeat R9.
    function automatic logic [15:0] entry_of(logic [3:0] idx, logic [6:0] vol, logic [2:0] sel);
        logic [8:0] r4;
        case (sel)
            3'd1:    r4 = 9'h01A;
            3'd2:    r4 = 9'h015;
            3'd3:    r4 = 9'h00A;
            default: r4 = 9'h012;
        endcase
        case (idx)
            4'd0:    entry_of = {7'h0F, 9'h000};
            4'd1:    entry_of = {7'h00, 9'h017};
            4'd2:    entry_of = {7'h01, 9'h017};
            4'd3:    entry_of = {7'h02, 2'b11, vol};
            4'd4:    entry_of = {7'h04, r4};
            4'd5:    entry_of = {7'h05, 9'h000};
            4'd6:    entry_of = {7'h06, 9'h000};
            4'd7:    entry_of = {7'h07, 9'h042};
            4'd8:    entry_of = {7'h08, 9'h000};
            default: entry_of = {7'h09, 9'h001};
        endcase
    endfunction

    assign qtick = (tick_q == TickLast);
    assign entry = entry_of(idx_q, vol_q, sel_q);

    always_comb begin
        state_d     = state_q;
        tick_d      = qtick ? 10'd0 : tick_q + 10'd1;
        phase_d     = phase_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        retry_d     = retry_q;
        vol_d       = vol_q;
        sel_d       = bus.sound_select;
        single_d    = single_q;
        again_d     = again_q;
        nack_d      = nack_q;
        scl_d       = scl_q;
        sda_low_d   = sda_low_q;
        done_d      = 1'b0;
        nack_err_d  = nack_err_q & ~bus.start;
        full_pend_d = full_pend_q | bus.start;
        vol_pend_d  = vol_pend_q;
        sel_pend_d  = sel_pend_q;

        unique case (state_q)
            StIdle: begin
                retry_d = '0;
                again_d = 1'b0;
                if (full_pend_q) begin
                    full_pend_d = bus.start;
                    single_d    = 1'b0;
                    idx_d       = 4'd0;
                    state_d     = StLoad;
                end else if (vol_pend_q) begin
                    single_d = 1'b1;
                    idx_d    = 4'd3;
                    state_d  = StLoad;
                end else if (sel_pend_q) begin
                    single_d = 1'b1;
                    idx_d    = 4'd4;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                shreg_d = {SLAVE_ADDR, 1'b0, entry};
                bit_d   = '0;
                phase_d = '0;
                nack_d  = 1'b0;
                state_d = StStart;
                if (idx_q == 4'd3) vol_pend_d = 1'b0;
                if (idx_q == 4'd4) sel_pend_d = 1'b0;
            end
            StStart: if (qtick) begin
                phase_d = phase_q + 2'd1;
                case (phase_q)
                    2'd0:    begin sda_low_d = 1'b0; scl_d = 1'b1; end
                    2'd1:    sda_low_d = 1'b1;
                    2'd3:    begin scl_d = 1'b0; state_d = StBit; end
                    default: ;
                endcase
            end
            StBit: if (qtick) begin
                phase_d = phase_q + 2'd1;
                case (phase_q)
                    2'd0:    sda_low_d = ~shreg_q[23];
                    2'd1:    scl_d = 1'b1;
                    2'd3: begin
                        scl_d   = 1'b0;
                        shreg_d = {shreg_q[22:0], 1'b0};
                        bit_d   = bit_q + 5'd1;
                        if (bit_q[2:0] == 3'd7) state_d = StAck;
                    end
                    default: ;
                endcase
            end
            StAck: if (qtick) begin
                phase_d = phase_q + 2'd1;
                case (phase_q)
                    2'd0: sda_low_d = 1'b0;
                    2'd1: scl_d = 1'b1;
                    2'd2: nack_d = I2C_SDAT;
                    default: begin
                        scl_d   = 1'b0;
                        state_d = (nack_q || bit_q == 5'd24) ? StStop : StBit;
                    end
                endcase
            end
            StStop: if (qtick) begin
                phase_d = phase_q + 2'd1;
                case (phase_q)
                    2'd0: sda_low_d = 1'b1;
                    2'd1: scl_d = 1'b1;
                    2'd2: sda_low_d = 1'b0;
                    default: begin
                        gap_d   = '0;
                        state_d = nack_q ? StErr : StGap;
                    end
                endcase
            end
            StErr: begin
                if (RetryEn && retry_q < MaxRetry) begin
                    retry_d = retry_q + 4'd1;
                    again_d = 1'b1;
                    state_d = StGap;
                end else begin
                    nack_err_d = 1'b1;
                    // Without retries a NACK aborts; with them we move on to the next entry.
                    state_d    = RetryEn ? StGap : StFinish;
                end
            end
            StGap: if (qtick) begin
                if (gap_q == GapLast) begin
                    gap_d = '0;
                    if (again_q) begin
                        again_d = 1'b0;
                        state_d = StLoad;
                    end else if (single_q || idx_q == LastIdx) begin
                        state_d = StFinish;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        retry_d = '0;
                        state_d = StLoad;
                    end
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // New changes win over the clear at LOAD so a late update is never lost.
        if (bus.volume_up && !bus.volume_down && vol_q != VolMax) begin
            vol_d      = vol_q + 7'd1;
            vol_pend_d = 1'b1;
        end else if (bus.volume_down && !bus.volume_up && vol_q > VOL_MIN) begin
            vol_d      = vol_q - 7'd1;
            vol_pend_d = 1'b1;
        end
        if (bus.sound_select != sel_q) sel_pend_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            tick_q      <= '0;
            phase_q     <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            retry_q     <= '0;
            vol_q       <= VOL_DEFAULT;
            sel_q       <= bus.sound_select;
            single_q    <= 1'b0;
            again_q     <= 1'b0;
            nack_q      <= 1'b0;
            scl_q       <= 1'b1;
            sda_low_q   <= 1'b0;
            done_q      <= 1'b0;
            nack_err_q  <= 1'b0;
            full_pend_q <= 1'b1;
            vol_pend_q  <= 1'b0;
            sel_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            retry_q     <= retry_d;
            vol_q       <= vol_d;
            sel_q       <= sel_d;
            single_q    <= single_d;
            again_q     <= again_d;
            nack_q      <= nack_d;
            scl_q       <= scl_d;
            sda_low_q   <= sda_low_d;
            done_q      <= done_d;
            nack_err_q  <= nack_err_d;
            full_pend_q <= full_pend_d;
            vol_pend_q  <= vol_pend_d;
            sel_pend_q  <= sel_pend_d;
        end
    end

    assign I2C_SDAT     = sda_low_q ? 1'b0 : 1'bz;
    assign I2C_SCLK     = scl_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done_q;
    assign bus.nack_err = nack_err_q;
    assign bus.volume   = vol_q;

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Bench for wm8731_cfg_seq: an I2C slave model feeds received frames to a scoreboard of expected frames.
module tb_wm8731_cfg_seq;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic scl;
    wire  sdat;
    logic slave_drive = 1'b0;
    bit   nack_r1 = 1'b0;

    pullup (sdat);
    assign sdat = slave_drive ? 1'b0 : 1'bz;

    wm8731_cfg_seq_if bus ();

    wm8731_cfg_seq #(.CLK_DIV(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .I2C_SDAT (sdat),
        .I2C_SCLK (scl)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [23:0] data;
        int          nbytes;
    } frame_t;

    typedef struct {
        logic [2:0] sel;
        int         n_up;
        int         n_down;
        int         n_both;
        logic [6:0] exp_vol;
        logic [8:0] exp_r4;
        bit         r2_write;
    } vec_t;

    frame_t      exp_q[$];
    logic [23:0] rx_log[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;

    logic [6:0]  seq_reg[10] = '{7'h0F, 7'h00, 7'h01, 7'h02, 7'h04,
                                 7'h05, 7'h06, 7'h07, 7'h08, 7'h09};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] r4_of(input logic [2:0] s);
        case (s)
            3'd1:    return 9'h01A;
            3'd2:    return 9'h015;
            3'd3:    return 9'h00A;
            default: return 9'h012;
        endcase
    endfunction

    function automatic logic [8:0] seq_data(input int i, input logic [6:0] vol, input logic [2:0] s);
        case (i)
            1, 2:    return 9'h017;
            3:       return {2'b11, vol};
            4:       return r4_of(s);
            7:       return 9'h042;
            9:       return 9'h001;
            default: return 9'h000;
        endcase
    endfunction

    task automatic push_frame(input logic [6:0] r, input logic [8:0] d, input int nb);
        frame_t f;
        f.nbytes = nb;
        f.data   = (nb == 3) ? {8'h34, r, d} : {8'h00, 8'h34, r, d[8]};
        exp_q.push_back(f);
    endtask

    task automatic push_full(input logic [6:0] vol, input logic [2:0] s);
        for (int i = 0; i < 10; i++) push_frame(seq_reg[i], seq_data(i, vol, s), 3);
    endtask

    task automatic score(input logic [23:0] d, input int nb);
        frame_t e;
        n_checks++;
        rx_log.push_back(d);
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL frame: got %06h (%0d bytes), expected none", d, nb);
        end else begin
            e = exp_q.pop_front();
            if (e.data !== d || e.nbytes != nb) begin
                n_errors++;
                $display("FAIL frame: got %06h (%0d bytes), expected %06h (%0d bytes)",
                         d, nb, e.data, e.nbytes);
            end
        end
    endtask

    // I2C slave: ACKs every byte except the register byte of R1 when nack_r1 is set.
    logic        prev_scl = 1'b1, prev_sda = 1'b1;
    logic        in_frame = 1'b0, in_ack = 1'b0;
    int          bitpos = 0, nbytes = 0;
    logic [7:0]  cur_byte = '0;
    logic [23:0] rx_data = '0;

    always @(negedge clock) begin
        logic scl_now, sda_now;
        scl_now = scl;
        sda_now = sdat;
        if (reset) begin
            in_frame    = 1'b0;
            in_ack      = 1'b0;
            slave_drive = 1'b0;
        end else if (prev_scl && scl_now && prev_sda && !sda_now) begin
            in_frame = 1'b1;
            in_ack   = 1'b0;
            bitpos   = 0;
            nbytes   = 0;
            rx_data  = '0;
        end else if (prev_scl && scl_now && !prev_sda && sda_now && in_frame) begin
            in_frame    = 1'b0;
            slave_drive = 1'b0;
            score(rx_data, nbytes);
        end else if (in_frame && !prev_scl && scl_now && !in_ack) begin
            cur_byte = {cur_byte[6:0], sda_now};
            bitpos++;
        end else if (in_frame && prev_scl && !scl_now) begin
            if (in_ack) begin
                in_ack      = 1'b0;
                slave_drive = 1'b0;
                bitpos      = 0;
            end else if (bitpos == 8) begin
                in_ack      = 1'b1;
                rx_data     = {rx_data[15:0], cur_byte};
                nbytes++;
                slave_drive = !(nack_r1 && nbytes == 2 && cur_byte == 8'h02);
            end
        end
        prev_scl = scl_now;
        prev_sda = sda_now;
    end

    always @(negedge clock) if (!reset && bus.done) done_cnt++;

    task automatic wait_dones(input int n, input int budget, input string name);
        int target;
        int cyc;
        target = done_cnt + n;
        cyc    = 0;
        while (done_cnt < target && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
        check({name, " done count"}, done_cnt, target);
    endtask

    task automatic wait_rx(input int target, input int budget, input string name);
        int cyc;
        cyc = 0;
        while (rx_log.size() < target && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
        check({name, " frames seen"}, rx_log.size(), target);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    vec_t        vecs[5];
    int          base;
    int          cyc;
    logic [23:0] got;

    initial begin
        vecs[0] = '{3'd2, 7, 0,  0, 7'h7F, 9'h015, 1'b1};
        vecs[1] = '{3'd1, 0, 80, 0, 7'h30, 9'h01A, 1'b1};
        vecs[2] = '{3'd3, 3, 0,  0, 7'h33, 9'h00A, 1'b1};
        vecs[3] = '{3'd5, 0, 0,  5, 7'h33, 9'h012, 1'b0};
        vecs[4] = '{3'd0, 0, 0,  0, 7'h33, 9'h012, 1'b0};

        bus.start        = 1'b0;
        bus.volume_up    = 1'b0;
        bus.volume_down  = 1'b0;
        bus.sound_select = 3'd0;

        // Reset state and the automatic init sequence.
        repeat (4) @(negedge clock);
        check("reset scl", scl, 1'b1);
        check("reset sdat", sdat, 1'b1);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset nack_err", bus.nack_err, 1'b0);
        check("reset volume", bus.volume, 7'h79);
        push_full(7'h79, 3'd0);
        reset = 1'b0;
        @(negedge clock);
        check("auto-start busy", bus.busy, 1'b1);
        wait_dones(1, 8000, "init");
        repeat (20) @(negedge clock);
        check("init single done", done_cnt, 1);
        check("init busy low", bus.busy, 1'b0);
        check("init frames left", exp_q.size(), 0);
        got = (rx_log.size() > 3) ? rx_log[0] : 24'hx;
        check("init frame 0", got, 24'h341E00);
        got = (rx_log.size() > 3) ? rx_log[3] : 24'hx;
        check("init frame 3", got, 24'h3405F9);

        // sound_select change launches R4; volume pulses land during it and queue one R2.
        for (int v = 0; v < 5; v++) begin
            bus.sound_select = vecs[v].sel;
            push_frame(7'h04, vecs[v].exp_r4, 3);
            repeat (10) @(negedge clock);
            for (int k = 0; k < vecs[v].n_up; k++) begin
                bus.volume_up = 1'b1;
                @(negedge clock);
                bus.volume_up = 1'b0;
                @(negedge clock);
            end
            if (vecs[v].n_down > 0) begin
                bus.volume_down = 1'b1;
                repeat (vecs[v].n_down) @(negedge clock);
                bus.volume_down = 1'b0;
            end
            for (int k = 0; k < vecs[v].n_both; k++) begin
                bus.volume_up   = 1'b1;
                bus.volume_down = 1'b1;
                @(negedge clock);
                bus.volume_up   = 1'b0;
                bus.volume_down = 1'b0;
                @(negedge clock);
            end
            if (vecs[v].r2_write) push_frame(7'h02, {2'b11, vecs[v].exp_vol}, 3);
            wait_dones(vecs[v].r2_write ? 2 : 1, 3000, "update");
            repeat (10) @(negedge clock);
            check("update volume", bus.volume, vecs[v].exp_vol);
            check("update frames left", exp_q.size(), 0);
            check("update busy low", bus.busy, 1'b0);
        end

        // Volume reacts on the very next cycle even from idle.
        push_frame(7'h02, {2'b11, 7'h34}, 3);
        bus.volume_up = 1'b1;
        @(negedge clock);
        bus.volume_up = 1'b0;
        check("volume next cycle", bus.volume, 7'h34);
        wait_dones(1, 3000, "single R2");
        check("single R2 frames left", exp_q.size(), 0);

        // start during frame 5 repeats the full sequence exactly once.
        push_full(7'h34, 3'd0);
        base = rx_log.size();
        pulse_start();
        wait_rx(base + 5, 4000, "start-busy");
        push_full(7'h34, 3'd0);
        pulse_start();
        wait_dones(2, 16000, "start-busy");
        repeat (20) @(negedge clock);
        check("start-busy frames left", exp_q.size(), 0);
        check("start-busy count", rx_log.size(), base + 20);
        check("start-busy busy low", bus.busy, 1'b0);

        // Slave NACKs the R1 register byte every time.
        nack_r1 = 1'b1;
        push_frame(7'h0F, 9'h000, 3);
        push_frame(7'h00, 9'h017, 3);
`ifdef CFG_RETRY_EN
        for (int k = 0; k < 4; k++) push_frame(7'h01, 9'h017, 2);
        for (int i = 3; i < 10; i++) push_frame(seq_reg[i], seq_data(i, 7'h34, 3'd0), 3);
`else
        push_frame(7'h01, 9'h017, 2);
`endif
        pulse_start();
        wait_dones(1, 12000, "nack");
        repeat (40) @(negedge clock);
        check("nack_err set", bus.nack_err, 1'b1);
        check("nack frames left", exp_q.size(), 0);
        check("nack busy low", bus.busy, 1'b0);
        nack_r1 = 1'b0;
        push_full(7'h34, 3'd0);
        pulse_start();
        check("nack_err cleared", bus.nack_err, 1'b0);
        wait_dones(1, 8000, "post-nack");
        check("post-nack frames left", exp_q.size(), 0);

        // Reset mid-byte with SCL low and SDA driven low.
        push_full(7'h34, 3'd0);
        pulse_start();
        cyc = 0;
        while (!(in_frame && !in_ack && nbytes == 0 && bitpos == 1 && scl == 1'b0) && cyc < 3000) begin
            @(negedge clock);
            cyc++;
        end
        check("mid-frame reached", cyc < 3000, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        check("mid-reset scl", scl, 1'b1);
        check("mid-reset sdat", sdat, 1'b1);
        exp_q.delete();
        push_full(7'h79, 3'd0);
        base = rx_log.size();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        wait_dones(1, 8000, "restart");
        got = (rx_log.size() > base) ? rx_log[base] : 24'hx;
        check("restart first frame", got, 24'h341E00);
        check("restart frames left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
